// File: rtl/bist_pkg.sv
// Shared STRAIT BIST definitions: unloader state encoding and default datapath geometry.
package bist_pkg;

    localparam int unsigned BIST_ADDR_W = 4;
    localparam int unsigned BIST_DEPTH  = 16;
    localparam int unsigned BIST_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        EMIT,
        DONE
    } unload_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bist_result_unloader.sv
// Post-test readback: reads each accumulator RAM word, compares it to the golden ROM
// word and streams one result record per address over a valid/ready handshake.
module bist_result_unloader
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W = BIST_ADDR_W,
    parameter int unsigned DEPTH  = BIST_DEPTH,
    parameter int unsigned DATA_W = BIST_DATA_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_exp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_actual,
    output logic              out_fail,
    output logic [CNT_W-1:0]  fail_count,
    output logic              busy,
    output logic              done
);

    unload_state_t     state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              last;
    logic              launch;
    logic              handshake;

    assign last      = (ptr == ADDR_W'(DEPTH - 1));
    assign launch    = ((state == IDLE) || (state == DONE)) && start && !abort;
    assign handshake = (state == EMIT) && out_ready && !abort;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = ISSUE;
            ISSUE:      state_nxt = CAPTURE;
            CAPTURE:    state_nxt = EMIT;
            EMIT:       if (out_ready) state_nxt = last ? DONE : ISSUE;
            default:    state_nxt = IDLE;
        endcase
        // abort overrides every transition, including a start in IDLE/DONE
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            out_addr   <= '0;
            out_actual <= '0;
            out_fail   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                ptr <= '0;
            end else if (handshake && !last) begin
                ptr <= ptr + 1'b1;
            end
            if (state == CAPTURE) begin
                out_addr   <= ptr;
                out_actual <= ram_rd_data;
                out_fail   <= (ram_rd_data != rom_exp_data);
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_fail_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .inc  (handshake && out_fail),
        .count(fail_count)
    );

    assign ram_rd_en   = (state == ISSUE);
    assign ram_rd_addr = ptr;
    assign rom_addr    = ptr;
    assign out_valid   = (state == EMIT);
    assign busy        = (state == ISSUE) || (state == CAPTURE) || (state == EMIT);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_bist_result_unloader.sv
// Bench for bist_result_unloader: two instances (8-bit and 3-bit fail counters) share
// stimulus and memories; a record-level model checks every cycle, literals pin timing.
module tb_bist_result_unloader;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [31:0] ram [16];
    logic [31:0] rom [16];

    logic        rd_en_a, ov_a, ofail_a, busy_a, done_a;
    logic [3:0]  rd_addr_a, rom_addr_a, oaddr_a;
    logic [31:0] ram_q_a, rom_exp_a, oact_a;
    logic [7:0]  fcnt_a;

    logic        rd_en_b, ov_b, ofail_b, busy_b, done_b;
    logic [3:0]  rd_addr_b, rom_addr_b, oaddr_b;
    logic [31:0] ram_q_b, rom_exp_b, oact_b;
    logic [2:0]  fcnt_b;

    logic        any_a, any_b;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    bist_result_unloader #(.ADDR_W(4), .DEPTH(16), .DATA_W(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ram_rd_en(rd_en_a), .ram_rd_addr(rd_addr_a), .ram_rd_data(ram_q_a),
        .rom_addr(rom_addr_a), .rom_exp_data(rom_exp_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_addr(oaddr_a),
        .out_actual(oact_a), .out_fail(ofail_a), .fail_count(fcnt_a),
        .busy(busy_a), .done(done_a)
    );

    bist_result_unloader #(.ADDR_W(4), .DEPTH(16), .DATA_W(32), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ram_rd_en(rd_en_b), .ram_rd_addr(rd_addr_b), .ram_rd_data(ram_q_b),
        .rom_addr(rom_addr_b), .rom_exp_data(rom_exp_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_addr(oaddr_b),
        .out_actual(oact_b), .out_fail(ofail_b), .fail_count(fcnt_b),
        .busy(busy_b), .done(done_b)
    );

    // Synchronous-read RAM and combinational ROM, one read port per instance.
    always @(posedge clk) begin
        if (rd_en_a) ram_q_a <= ram[rd_addr_a];
        if (rd_en_b) ram_q_b <= ram[rd_addr_b];
    end
    assign rom_exp_a = rom[rom_addr_a];
    assign rom_exp_b = rom[rom_addr_b];

    assign any_a = |{rd_en_a, rd_addr_a, rom_addr_a, ov_a, oaddr_a, oact_a, ofail_a,
                     fcnt_a, busy_a, done_a};
    assign any_b = |{rd_en_b, rd_addr_b, rom_addr_b, ov_b, oaddr_b, oact_b, ofail_b,
                     fcnt_b, busy_b, done_b};

    function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endfunction

    // Record-level model: which address is next, whether a run is in progress,
    // and how many failing records have been delivered (clipped to the counter max).
    int m_next [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    bit m_run  [2] = '{0, 0};
    bit m_done [2] = '{0, 0};
    bit m_zero [2] = '{1, 1};
    int lim    [2] = '{255, 7};

    task automatic mon(input int d, input logic ov, input logic [3:0] oaddr,
                       input logic [31:0] oact, input logic ofail, input logic [7:0] fcnt,
                       input logic bsy, input logic dn, input logic rden,
                       input logic [3:0] rdaddr, input logic anyout);
        if (m_zero[d]) check($sformatf("reset_zero%0d", d), anyout, 0);
        check($sformatf("fail_count%0d", d), fcnt, m_cnt[d]);
        check($sformatf("busy%0d", d), bsy, m_run[d]);
        check($sformatf("done%0d", d), dn, m_done[d]);
        if (ov) begin
            check($sformatf("rec_addr%0d", d), oaddr, m_next[d]);
            check($sformatf("rec_actual%0d", d), oact, ram[m_next[d]]);
            check($sformatf("rec_fail%0d", d), ofail, ram[m_next[d]] != rom[m_next[d]]);
            check($sformatf("read_in_emit%0d", d), rden, 0);
        end
        if (rden) check($sformatf("rd_addr%0d", d), rdaddr, m_next[d]);

        if (!rst) begin
            m_run[d] = 0; m_done[d] = 0; m_cnt[d] = 0; m_next[d] = 0; m_zero[d] = 1;
        end else begin
            m_zero[d] = 0;
            if (abort) begin
                m_run[d] = 0; m_done[d] = 0;
            end else if (start && !m_run[d]) begin
                m_run[d] = 1; m_done[d] = 0; m_next[d] = 0; m_cnt[d] = 0;
            end else if (ov && out_ready) begin
                if (ram[m_next[d]] != rom[m_next[d]] && m_cnt[d] < lim[d]) m_cnt[d]++;
                if (m_next[d] == 15) begin
                    m_run[d] = 0; m_done[d] = 1;
                end else begin
                    m_next[d]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ov_a, oaddr_a, oact_a, ofail_a, fcnt_a, busy_a, done_a, rd_en_a, rd_addr_a, any_a);
            mon(1, ov_b, oaddr_b, oact_b, ofail_b, {5'b0, fcnt_b}, busy_b, done_b, rd_en_b, rd_addr_b, any_b);
        end
    end

    // Pulses start (edge 0), then drives cycles 1.. until done; returns the first done
    // cycle, -1 when stopped by abort/reset (now in the following cycle), 0 on timeout.
    task automatic run_seq(input int stall_from, input int stall_to, input int ign_start,
                           input int abort_at, input int rst_at, input bit rand_ready,
                           output int done_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = 0;
        for (int c = 1; c < 400; c++) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0)
                                   : !(c >= stall_from && c <= stall_to);
            start = (c == ign_start);
            abort = (c == abort_at);
            rst   = !(c == rst_at);
            if ((abort_at > 0 && c == abort_at + 1) || (rst_at > 0 && c == rst_at + 1)) begin
                done_cyc = -1;
                break;
            end
            if (done_a && done_b) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int dc;
        int nf;
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rom[i] = $urandom;
            ram[i] = rom[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", any_a, 0);
        check("reset_outputs_b", any_b, 0);
        mon_en = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Clean pass with a start pulse while busy at cycle 10.
        run_seq(0, -1, 10, 0, 0, 0, dc);
        check("s1_done_cycle", dc, 49);
        check("s1_cnt_a", fcnt_a, 0);
        check("s1_cnt_b", fcnt_b, 0);

        // Single-bit corruption at address 5, restarted from DONE.
        ram[5] = rom[5] ^ 32'h0000_0001;
        run_seq(0, -1, 0, 0, 0, 0, dc);
        check("s2_done_cycle", dc, 49);
        check("s2_cnt_a", fcnt_a, 1);
        check("s2_cnt_b", fcnt_b, 1);

        // Four stall cycles while record 2 is valid (cycles 9..12).
        ram[5] = rom[5];
        run_seq(9, 12, 0, 0, 0, 0, dc);
        check("s3_done_cycle", dc, 53);
        check("s3_cnt_a", fcnt_a, 0);

        // Every word corrupted: 8-bit counter reaches 16, 3-bit counter saturates at 7.
        for (int i = 0; i < 16; i++) ram[i] = rom[i] ^ (32'h1 << i);
        run_seq(0, -1, 0, 0, 0, 0, dc);
        check("s4_done_cycle", dc, 49);
        check("s4_cnt_a", fcnt_a, 16);
        check("s4_cnt_b", fcnt_b, 7);

        // Abort at cycle 20 after records 0..5 (0..4 failing) were delivered.
        for (int i = 0; i < 16; i++) ram[i] = (i < 5) ? ~rom[i] : rom[i];
        run_seq(0, -1, 0, 20, 0, 0, dc);
        check("s5_stopped", dc, -1);
        check("s5_busy", busy_a, 0);
        check("s5_valid", ov_a, 0);
        check("s5_done", done_a, 0);
        check("s5_cnt_a", fcnt_a, 5);
        check("s5_cnt_b", fcnt_b, 5);

        // Reset during EMIT of record 7 (cycle 24).
        for (int i = 0; i < 16; i++) ram[i] = ~rom[i];
        run_seq(0, -1, 0, 0, 24, 0, dc);
        check("s6_stopped", dc, -1);
        check("s6_zero_a", any_a, 0);
        check("s6_zero_b", any_b, 0);

        // Random data and random backpressure.
        for (int r = 0; r < 3; r++) begin
            nf = 0;
            for (int i = 0; i < 16; i++) begin
                rom[i] = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    ram[i] = rom[i] ^ ($urandom | 32'h1);
                    nf++;
                end else begin
                    ram[i] = rom[i];
                end
            end
            run_seq(0, -1, 0, 0, 0, 1, dc);
            check("s7_done_reached", dc > 0, 1);
            check("s7_cnt_a", fcnt_a, nf);
            check("s7_cnt_b", fcnt_b, (nf > 7) ? 7 : nf);
        end

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
